// File: rtl/blink_seq_pkg.sv
// blink_seq_pkg: shared state encoding and constants for the blink sequencer
package blink_seq_pkg;
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    localparam int TICKS_MIN = 1;
endpackage

// File: rtl/blink_seq_timer.sv
// blink_seq_timer: prescaler plus tick counter timing one ON/OFF phase
// start clears both counters and latches max(dur, 1); expire pulses on the phase's last cycle.
module blink_seq_timer
    import blink_seq_pkg::*;
#(
    parameter int PRESCALE = 60000,
    parameter int TIME_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [TIME_W-1:0] dur,
    output logic              expire
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0]     pre;
    logic [TIME_W-1:0] tick;
    logic [TIME_W-1:0] term;
    logic              active;
    logic              pre_end;
    assign pre_end = pre == PW'(PRESCALE - 1);
    assign expire  = active & pre_end & (tick == term - TIME_W'(1));
    // count prescaled ticks from each phase entry; stop at expiry so nothing wraps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre    <= '0;
            tick   <= '0;
            term   <= '0;
            active <= 1'b0;
        end else if (start) begin
            pre    <= '0;
            tick   <= '0;
            term   <= (dur == '0) ? TIME_W'(TICKS_MIN) : dur;
            active <= 1'b1;
        end else if (active) begin
            pre    <= pre_end ? '0 : pre + PW'(1);
            tick   <= pre_end ? tick + TIME_W'(1) : tick;
            active <= ~expire;
        end
    end
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: command-driven LED blink controller (ON/OFF phases in prescaled ticks)
// Optional feature: BLINK_SEQ_REPEAT_EN adds cmd_repeat for endlessly repeating patterns.
module blink_sequencer
    import blink_seq_pkg::*;
#(
    parameter int PRESCALE = 60000,
    parameter int TIME_W   = 16,
    parameter int COUNT_W  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic [TIME_W-1:0]  cmd_on,
    input  logic [TIME_W-1:0]  cmd_off,
    input  logic               abort,
`ifdef BLINK_SEQ_REPEAT_EN
    input  logic               cmd_repeat,
`endif
    output logic               blink,
    output logic               busy,
    output logic               done
);
    state_t             state, state_n;
    logic [COUNT_W-1:0] remaining, rem_n, reload;
    logic [TIME_W-1:0]  on_l, off_l, dur;
    logic               accept, start, expire, done_n, rep;
    assign cmd_ready = reset_n & (state == IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = state != IDLE;
`ifdef BLINK_SEQ_REPEAT_EN
    logic               rep_l;
    logic [COUNT_W-1:0] count_l;
    // keep the repeat flag and full count so a repeating pattern can restart
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rep_l   <= 1'b0;
            count_l <= '0;
        end else if (abort) begin
            rep_l   <= 1'b0;
            count_l <= '0;
        end else if (accept) begin
            rep_l   <= cmd_repeat;
            count_l <= cmd_count;
        end
    end
    assign rep    = rep_l;
    assign reload = count_l;
`else
    assign rep    = 1'b0;
    assign reload = '0;
`endif
    blink_seq_timer #(.PRESCALE(PRESCALE), .TIME_W(TIME_W)) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .dur    (dur),
        .expire (expire)
    );
    // next state, phase restarts and completion; abort overrides everything
    always_comb begin
        state_n = state;
        rem_n   = remaining;
        start   = 1'b0;
        done_n  = 1'b0;
        dur     = on_l;
        if (abort) begin
            state_n = IDLE;
            rem_n   = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (cmd_count == '0) done_n = 1'b1;
                    else begin
                        state_n = ON;
                        rem_n   = cmd_count;
                        start   = 1'b1;
                        dur     = cmd_on;
                    end
                end
                ON: if (expire) begin
                    if (remaining == COUNT_W'(1) && !rep) begin
                        state_n = IDLE;
                        rem_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        rem_n   = (remaining == COUNT_W'(1)) ? reload : remaining - COUNT_W'(1);
                        state_n = (off_l != '0) ? OFF : ON;
                        dur     = (off_l != '0) ? off_l : on_l;
                        start   = 1'b1;
                    end
                end
                OFF: if (expire) begin
                    state_n = ON;
                    start   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    // state, latched command fields and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            on_l      <= '0;
            off_l     <= '0;
            blink     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            blink     <= state_n == ON;
            done      <= done_n;
            if (abort) begin
                on_l  <= '0;
                off_l <= '0;
            end else if (accept) begin
                on_l  <= cmd_on;
                off_l <= cmd_off;
            end
        end
    end
endmodule
